// File: rtl/nv_nvdla_cacc_pkg.sv
// Shared CACC definitions.
// Contents: datapath widths, calculator partial-sum latency, partial-sum type and
// a saturating 32-bit increment used by the status counters.
package nv_nvdla_cacc_pkg;

  localparam int unsigned CACC_PSUM_W        = 34;
  localparam int unsigned CACC_DAT_W         = 22;
  // Cycles from accept to partial-sum writeback from the calculator.
  localparam int unsigned CACC_CALC_PSUM_LAT = 3;

  typedef logic [CACC_PSUM_W-1:0] cacc_psum_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] cacc_sat_inc(input logic [31:0] cnt);
    return (&cnt) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/nv_nvdla_cacc_psum_ram.sv
// Partial-sum storage: DEPTH x CACC_PSUM_W flop array (not reset) with a
// synchronous write port and a registered read port.
// Ports:
//   nvdla_core_clk / nvdla_core_rst : clock, synchronous active-high reset
//   wr_en_i, wr_addr_i, wr_data_i   : write port, commits at the clock edge
//   rd_en_i, rd_addr_i, rd_zero_i   : read request; rd_zero_i loads zero instead
//   rd_data_o                       : registered read data, holds between reads
module nv_nvdla_cacc_psum_ram
  import nv_nvdla_cacc_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  cacc_psum_t    wr_data_i,
  input  logic          rd_en_i,
  input  logic          rd_zero_i,
  input  logic [AW-1:0] rd_addr_i,
  output cacc_psum_t    rd_data_o
);

  cacc_psum_t mem_q [DEPTH];
  cacc_psum_t rd_data_q;

  always_ff @(posedge nvdla_core_clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Only the output register is reset so the issued operand starts at zero.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= rd_zero_i ? '0 : mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/nv_nvdla_cacc_psum_buf.sv
// Partial-sum store and issue stage in front of the CACC int8 calculator.
// Accepts per-atom product data, issues it one cycle later with the stored
// partial sum of the same atom, captures the calculator's writeback for the next
// stripe and counts saturated final results.
// Ports:
//   nvdla_core_clk, nvdla_core_rst       : clock, synchronous active-high reset
//   cfg_stripe_len, cfg_layer_start      : atoms per stripe, pointer/counter clear
//   dat_valid/dat_ready, dat_data,
//   dat_first, dat_last                  : upstream product-sum handshake
//   calc_in_*                            : issue to the calculator
//   calc_out_partial_valid/data          : partial-sum writeback
//   calc_out_final_valid/sat             : final-result saturation status
//   sat_cnt, idle, err                   : status
module nv_nvdla_cacc_psum_buf
  import nv_nvdla_cacc_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic [AW:0]           cfg_stripe_len,
  input  logic                  cfg_layer_start,
  input  logic                  dat_valid,
  output logic                  dat_ready,
  input  logic [CACC_DAT_W-1:0] dat_data,
  input  logic                  dat_first,
  input  logic                  dat_last,
  output logic                  calc_in_valid,
  output logic [CACC_DAT_W-1:0] calc_in_data,
  output logic                  calc_in_sel,
  output cacc_psum_t            calc_in_op,
  output logic                  calc_in_op_valid,
  input  logic                  calc_out_partial_valid,
  input  cacc_psum_t            calc_out_partial_data,
  input  logic                  calc_out_final_valid,
  input  logic                  calc_out_final_sat,
  output logic [31:0]           sat_cnt,
  output logic                  idle,
  output logic                  err
);

  logic                  accept;
  logic                  layer_clr;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0]      pending_q, pending_d;
  logic                  err_q, err_d;
  logic                  calc_in_valid_q;
  logic                  calc_in_sel_q;
  logic                  calc_in_op_valid_q;
  logic [CACC_DAT_W-1:0] calc_in_data_q;
  logic [31:0]           sat_cnt_q;

  // Wrap at the configured stripe length rather than at DEPTH.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr, input logic [AW:0] len);
    logic [AW:0] last_idx;
    last_idx = len - (AW+1)'(1);
    if ({1'b0, ptr} == last_idx) begin
      return '0;
    end
    return ptr + AW'(1);
  endfunction

  // A non-first read must wait until the previous stripe's writeback commits.
  assign dat_ready = ~(pending_q[rd_ptr_q] & ~dat_first);
  assign accept    = dat_valid & dat_ready;
  assign idle      = ~(|pending_q) & ~calc_in_valid_q;
  assign layer_clr = cfg_layer_start & idle;

  always_comb begin
    pending_d = pending_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    err_d     = err_q;
    // Clear before set so a same-entry set in the same cycle wins.
    if (calc_out_partial_valid) begin
      pending_d[wr_ptr_q] = 1'b0;
      wr_ptr_d            = ptr_inc(wr_ptr_q, cfg_stripe_len);
      if (!pending_q[wr_ptr_q]) begin
        err_d = 1'b1;
      end
    end
    if (accept) begin
      if (!dat_last) begin
        pending_d[rd_ptr_q] = 1'b1;
      end
      rd_ptr_d = ptr_inc(rd_ptr_q, cfg_stripe_len);
    end
    if (cfg_layer_start && !idle) begin
      err_d = 1'b1;
    end
    if (layer_clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      rd_ptr_q           <= '0;
      wr_ptr_q           <= '0;
      pending_q          <= '0;
      err_q              <= 1'b0;
      calc_in_valid_q    <= 1'b0;
      calc_in_sel_q      <= 1'b0;
      calc_in_op_valid_q <= 1'b0;
      calc_in_data_q     <= '0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      pending_q       <= pending_d;
      err_q           <= err_d;
      calc_in_valid_q <= accept;
      if (accept) begin
        calc_in_data_q     <= dat_data;
        calc_in_sel_q      <= dat_last;
        calc_in_op_valid_q <= ~dat_first;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      sat_cnt_q <= '0;
    end else if (layer_clr) begin
      sat_cnt_q <= '0;
    end else if (calc_out_final_valid && calc_out_final_sat) begin
      sat_cnt_q <= cacc_sat_inc(sat_cnt_q);
    end
  end

  nv_nvdla_cacc_psum_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_psum_ram (
    .nvdla_core_clk(nvdla_core_clk),
    .nvdla_core_rst(nvdla_core_rst),
    .wr_en_i       (calc_out_partial_valid),
    .wr_addr_i     (wr_ptr_q),
    .wr_data_i     (calc_out_partial_data),
    .rd_en_i       (accept),
    .rd_zero_i     (dat_first),
    .rd_addr_i     (rd_ptr_q),
    .rd_data_o     (calc_in_op)
  );

  assign calc_in_valid    = calc_in_valid_q;
  assign calc_in_data     = calc_in_data_q;
  assign calc_in_sel      = calc_in_sel_q;
  assign calc_in_op_valid = calc_in_op_valid_q;
  assign sat_cnt          = sat_cnt_q;
  assign err              = err_q;

endmodule
